// File: rtl/xeng_pkg.sv
// xeng_pkg: shared X-engine constants, FSM state type and saturating arithmetic helpers
package xeng_pkg;
  localparam int N_ANTS = 32;
  function automatic int frame_len(input int n);
    return n * (n / 2 + 1);
  endfunction
  localparam int DEFAULT_FRAME_LEN = frame_len(N_ANTS);
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;
  function automatic logic signed [63:0] clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] s, m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return s > m ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/delay.sv
// delay: resettable fixed-depth shift register for pipeline/side-band alignment
module delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH*DEPTH-1:0] sr;
  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk) sr <= rst ? '0 : d;
  end else begin : g_many
    always_ff @(posedge clk) sr <= rst ? '0 : {sr[WIDTH*(DEPTH-1)-1:0], d};
  end
  assign q = sr[WIDTH*DEPTH-1 -: WIDTH];
endmodule

// File: rtl/xeng_correction_apply_sp_sat_sub.sv
// sat_sub: registered signed a - b clamped to Q_W bits, with overflow flag
module sat_sub import xeng_pkg::*; #(
  parameter int A_W = 32,
  parameter int B_W = 16,
  parameter int Q_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [Q_W-1:0] q,
  output logic           ovf
);
  logic signed [A_W:0] diff;
  logic signed [63:0] full, sat;
  always_comb begin
    diff = $signed({a[A_W-1], a}) - $signed({{(A_W + 1 - B_W){b[B_W-1]}}, b});
    full = 64'(diff);
    sat = clamp(full, Q_W);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      ovf <= 1'b0;
    end else begin
      q <= sat[Q_W-1:0];
      ovf <= sat != full;
    end
  end
endmodule

// File: rtl/xeng_correction_apply_sp.sv
// xeng_correction_apply_sp: subtract tracker corrections, saturate, realign frames on buf_sel toggles
module xeng_correction_apply_sp import xeng_pkg::*; #(
  parameter int CORR_WIDTH = 32,
  parameter int CORRECTION_WIDTH = 16,
  parameter int OUT_WIDTH = 32,
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync,
  input  logic [CORR_WIDTH-1:0]       din_re,
  input  logic [CORR_WIDTH-1:0]       din_im,
  input  logic                        din_vld,
  input  logic [CORRECTION_WIDTH-1:0] re_correction_xx,
  input  logic [CORRECTION_WIDTH-1:0] im_correction_xx,
  input  logic                        last_triangle,
  input  logic                        buf_sel,
  output logic [OUT_WIDTH-1:0]        dout_re,
  output logic [OUT_WIDTH-1:0]        dout_im,
  output logic                        dout_vld,
  output logic                        dout_first,
  output logic                        dout_last_tri,
  output logic                        sync_out,
  output logic                        err_frame,
  output logic [7:0]                  err_cnt,
  output logic [15:0]                 sat_cnt
);
  localparam int CW = $clog2(FRAME_LEN + 2);
  localparam logic [CW-1:0] FL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FL1 = CW'(FRAME_LEN + 1);
  localparam int DW = 2 * CORR_WIDTH + 2 * CORRECTION_WIDTH;
  logic [CORR_WIDTH-1:0] s1_re, s1_im;
  logic [CORRECTION_WIDTH-1:0] s1_cre, s1_cim;
  logic s1_sync, s1_lt, s1_vld, s1_bs, bs_prev, toggle, emit, first, err, ovf_re, ovf_im;
  logic [CW-1:0] cnt, cnt_nxt;
  state_t st, nxt;
  delay #(.WIDTH(DW + 4), .DEPTH(1)) u_s1 (
    .clk(clk), .rst(rst),
    .d({din_re, din_im, re_correction_xx, im_correction_xx, sync, last_triangle, din_vld, buf_sel}),
    .q({s1_re, s1_im, s1_cre, s1_cim, s1_sync, s1_lt, s1_vld, s1_bs})
  );
  delay #(.WIDTH(2), .DEPTH(1)) u_side (
    .clk(clk), .rst(rst), .d({s1_sync, s1_lt}), .q({sync_out, dout_last_tri})
  );
  sat_sub #(.A_W(CORR_WIDTH), .B_W(CORRECTION_WIDTH), .Q_W(OUT_WIDTH)) u_re (
    .clk(clk), .rst(rst), .a(s1_re), .b(s1_cre), .q(dout_re), .ovf(ovf_re)
  );
  sat_sub #(.A_W(CORR_WIDTH), .B_W(CORRECTION_WIDTH), .Q_W(OUT_WIDTH)) u_im (
    .clk(clk), .rst(rst), .a(s1_im), .b(s1_cim), .q(dout_im), .ovf(ovf_im)
  );
  // a frame already flagged as overlong is not flagged again when it closes
  always_comb begin
    toggle = s1_vld && (s1_bs != bs_prev);
    nxt = st;
    emit = 1'b0;
    first = 1'b0;
    err = 1'b0;
    cnt_nxt = cnt;
    if (s1_sync) nxt = ALIGN;
    else if (st == ALIGN && toggle) begin
      nxt = RUN;
      emit = 1'b1;
      first = 1'b1;
      cnt_nxt = CW'(1);
    end else if (st == RUN && s1_vld) begin
      emit = 1'b1;
      first = toggle;
      err = toggle ? (cnt != FL && cnt != FL1) : (cnt == FL);
      cnt_nxt = toggle ? CW'(1) : (cnt >= FL ? FL1 : cnt + 1'b1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      bs_prev <= 1'b0;
      dout_vld <= 1'b0;
      dout_first <= 1'b0;
      err_frame <= 1'b0;
      err_cnt <= '0;
      sat_cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= cnt_nxt;
      bs_prev <= s1_vld ? s1_bs : bs_prev;
      dout_vld <= emit;
      dout_first <= first;
      err_frame <= err;
      err_cnt <= 8'(sat_add(32'(err_cnt), 32'(err), 8));
      sat_cnt <= 16'(sat_add(32'(sat_cnt), dout_vld ? 32'(ovf_re) + 32'(ovf_im) : 32'd0, 16));
    end
  end
endmodule
